// File: rtl/math_eq_pkg.sv
// Shared definitions for the equation solver (inverse of the evaluator
// q = ((1 + 3c)(a - b) - 4d) / 2).
// Width helpers take the operand width so parameterised instances stay
// consistent; the localparams give the widths for the default WIDTH of 8.
package math_eq_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  function automatic int unsigned q_w_of(input int unsigned w);
    return 2 * w + 4;
  endfunction

  function automatic int unsigned num_w_of(input int unsigned w);
    return 2 * w + 6;
  endfunction

  function automatic int unsigned den_w_of(input int unsigned w);
    return w + 3;
  endfunction

  function automatic int unsigned a_w_of(input int unsigned w);
    return 2 * w + 7;
  endfunction

  localparam int unsigned Q_W   = q_w_of(WIDTH_DEF);
  localparam int unsigned NUM_W = num_w_of(WIDTH_DEF);
  localparam int unsigned DEN_W = den_w_of(WIDTH_DEF);
  localparam int unsigned A_W   = a_w_of(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX,
    DONE
  } solver_state_t;

endpackage

// File: rtl/math_equation_solver_div.sv
// Unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               load dividend/divisor and begin (ignored state-wise while busy
//                       only by the caller; start always reloads)
//   dividend, divisor   unsigned operands (divisor must be non-zero)
//   busy                high while iterating
//   done                one-cycle pulse after the last iteration
//   quotient, remainder results, valid from done onwards until the next start
module seq_div_unsigned #(
  parameter int unsigned NUM_W = 22,
  parameter int unsigned DEN_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient,
  output logic [DEN_W-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(NUM_W + 1);

  // Dividend shifts out MSB-first while quotient bits shift in at the LSB,
  // so after NUM_W iterations this register holds the quotient.
  logic [NUM_W-1:0] dvd_r;
  logic [DEN_W-1:0] dvs_r;
  logic [DEN_W-1:0] rem_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;

  logic [DEN_W:0]   trial;
  logic [DEN_W:0]   diff;
  logic             fits;
  logic [DEN_W-1:0] rem_nxt;

  always_comb begin
    trial   = {rem_r, dvd_r[NUM_W-1]};
    diff    = trial - {1'b0, dvs_r};
    fits    = (trial >= {1'b0, dvs_r});
    // Either branch is below the divisor, so the top bit is always zero.
    rem_nxt = fits ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_r  <= '0;
      dvs_r  <= '0;
      rem_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      dvd_r  <= dividend;
      dvs_r  <= divisor;
      rem_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      dvd_r <= {dvd_r[NUM_W-2:0], fits};
      rem_r <= rem_nxt;
      cnt_r <= cnt_r + 1'b1;
      if (cnt_r == CNT_W'(NUM_W - 1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign quotient  = dvd_r;
  assign remainder = rem_r;

endmodule

// File: rtl/math_equation_solver.sv
// Recovers a = b + trunc((2q + 4d) / (1 + 3c)) from an evaluator result q.
// Signs are stripped before an unsigned iterative divide and restored
// afterwards (truncation toward zero, remainder follows the numerator).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_i, ready_o  input handshake (ready_o high only when idle)
//   q, b, c, d        signed operands (q is 2*WIDTH+4 bits)
//   valid_o, ready_i  output handshake; outputs hold until transferred
//   a_o               signed recovered a (2*WIDTH+7 bits)
//   rem_o             signed division remainder (WIDTH+3 bits)
//   exact_o           remainder is zero
module math_equation_solver
  import math_eq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [2*WIDTH+3:0]   q,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic [WIDTH-1:0]     d,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*WIDTH+6:0]   a_o,
  output logic [WIDTH+2:0]     rem_o,
  output logic                 exact_o
);

  localparam int unsigned QW = q_w_of(WIDTH);
  localparam int unsigned NW = num_w_of(WIDTH);
  localparam int unsigned DW = den_w_of(WIDTH);
  localparam int unsigned AW = a_w_of(WIDTH);

  solver_state_t state, state_nxt;

  logic [NW-1:0] q_ext, d_ext, num, num_mag;
  logic [DW-1:0] c_ext, den, den_mag;
  logic          start;

  logic          div_busy, div_done;
  logic [NW-1:0] quot;
  logic [DW-1:0] rem;

  logic [WIDTH-1:0] b_r;
  logic             sign_q_r, sign_r_r;
  logic [AW-1:0]    a_r;
  logic [DW-1:0]    rem_r;
  logic             exact_r;

  logic [NW-1:0] quot_s;
  logic [AW-1:0] a_nxt;
  logic [DW-1:0] rem_s;

  // Operand formation: NUM = 2q + 4d, DEN = 1 + 3c, both sign-extended first.
  always_comb begin
    q_ext   = {{(NW-QW){q[QW-1]}}, q};
    d_ext   = {{(NW-WIDTH){d[WIDTH-1]}}, d};
    num     = (q_ext << 1) + (d_ext << 2);
    c_ext   = {{(DW-WIDTH){c[WIDTH-1]}}, c};
    den     = c_ext + (c_ext << 1) + DW'(1);
    num_mag = num[NW-1] ? -num : num;
    den_mag = den[DW-1] ? -den : den;
    start   = valid_i && (state == IDLE);
  end

  seq_div_unsigned #(
    .NUM_W(NW),
    .DEN_W(DW)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (num_mag),
    .divisor  (den_mag),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quot),
    .remainder(rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_nxt = DIV;
      end
      DIV: begin
        if (div_done && !div_busy) state_nxt = FIX;
      end
      FIX: begin
        state_nxt = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sign restoration and the +b correction applied in FIX.
  always_comb begin
    quot_s = sign_q_r ? -quot : quot;
    rem_s  = sign_r_r ? -rem : rem;
    a_nxt  = {{(AW-WIDTH){b_r[WIDTH-1]}}, b_r} + {{(AW-NW){quot_s[NW-1]}}, quot_s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_r      <= '0;
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
      a_r      <= '0;
      rem_r    <= '0;
      exact_r  <= 1'b0;
    end else begin
      if (start) begin
        b_r      <= b;
        sign_q_r <= num[NW-1] ^ den[DW-1];
        sign_r_r <= num[NW-1];
      end
      if (state == FIX) begin
        a_r     <= a_nxt;
        rem_r   <= rem_s;
        exact_r <= (rem == '0);
      end
    end
  end

  assign a_o     = a_r;
  assign rem_o   = rem_r;
  assign exact_o = exact_r;

endmodule
